unidad_acceso_mem: RTL and testbench

// - Load/store access controller between the execute stage and data memory.
// - Upstream neighbour of the load trimmer: it issues word-aligned memory requests,

---
 rtl/unidad_acceso_mem_pkg.sv | 26 ++
 rtl/alineador_bytes.sv | 36 +++
 rtl/unidad_acceso_mem.sv | 137 +++++++++++++
 tb/tb_unidad_acceso_mem.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/unidad_acceso_mem_pkg.sv
// Shared definitions for the load/store access controller: size codes, FSM states
// and the alignment legality check.
package unidad_acceso_mem_pkg;

    localparam logic [1:0] SZ_BYTE   = 2'b00;
    localparam logic [1:0] SZ_HALF   = 2'b01;
    localparam logic [1:0] SZ_WORD   = 2'b10;
    localparam logic [1:0] SZ_ILEGAL = 2'b11;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StAccess = 2'b01,
        StResp   = 2'b10
    } state_t;

    // An access that must be answered with an error without touching memory.
    function automatic logic acceso_invalido(input logic [1:0] size, input logic [1:0] addr_lo);
        logic invalido;
        invalido = 1'b0;
        if (size == SZ_ILEGAL) invalido = 1'b1;
        else if (size == SZ_HALF && addr_lo[0]) invalido = 1'b1;
        else if (size == SZ_WORD && addr_lo != 2'b00) invalido = 1'b1;
        return invalido;
    endfunction

endpackage

// File: rtl/alineador_bytes.sv
// Byte-lane steering: byte enables, store-data replication and load right-alignment.
module alineador_bytes
    import unidad_acceso_mem_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_alin
);

    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << addr;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be        = 4'b0011 << addr;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
    end

    // Zero-filled shift; sign/zero extension is done downstream by the trimmer.
    assign rdata_alin = rdata >> {addr, 3'b000};

endmodule

// File: rtl/unidad_acceso_mem.sv
// Load/store access controller: issues word-aligned memory requests with byte enables,
// times out stalled accesses and returns right-aligned load data.
module unidad_acceso_mem
    import unidad_acceso_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_size,
    output logic        rsp_err
);

    state_t           state;
    logic [1:0]       addr_lo_q;
    logic [1:0]       size_q;
    logic [CNT_W-1:0] cnt;

    logic [1:0]  al_addr;
    logic [1:0]  al_size;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;

    // Steer the aligner from the live request while idle, from the captured one afterwards.
    always_comb begin
        al_addr = addr_lo_q;
        al_size = size_q;
        if (state == StIdle) begin
            al_addr = req_addr[1:0];
            al_size = req_size;
        end
    end

    alineador_bytes u_alineador (
        .addr       (al_addr),
        .size       (al_size),
        .wdata      (req_wdata),
        .rdata      (mem_rdata),
        .be         (al_be),
        .wdata_rep  (al_wdata),
        .rdata_alin (al_rdata)
    );

    assign req_ready = (state == StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            addr_lo_q <= 2'b00;
            size_q    <= 2'b00;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_size  <= 2'b00;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    rsp_valid <= 1'b0;
                    if (req_valid) begin
                        addr_lo_q <= req_addr[1:0];
                        size_q    <= req_size;
                        if (acceso_invalido(req_size, req_addr[1:0])) begin
                            state     <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0;
                            rsp_size  <= req_size;
                        end else begin
                            state     <= StAccess;
                            cnt       <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= al_be;
                            mem_wdata <= al_wdata;
                        end
                    end
                end
                StAccess: begin
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (mem_ack) begin
                        state     <= StResp;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_size  <= size_q;
                        rsp_rdata <= mem_we ? 32'h0 : al_rdata;
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state     <= StResp;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_size  <= size_q;
                        rsp_rdata <= 32'h0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                StResp: begin
                    rsp_valid <= 1'b0;
                    state     <= StIdle;
                end
                default: begin
                    rsp_valid <= 1'b0;
                    mem_req   <= 1'b0;
                    state     <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unidad_acceso_mem.sv
// Scoreboard bench for unidad_acceso_mem: directed cases plus randomized accesses
// checked against an arithmetic reference model.
module tb_unidad_acceso_mem;

    localparam int T = 4;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_size;
    logic        rsp_err;

    unidad_acceso_mem #(
        .TIMEOUT_CYCLES (T),
        .CNT_W          (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_wdata (req_wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_size  (rsp_size),
        .rsp_err   (rsp_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  size;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response pulse is compared with the oldest expected response.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response");
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_size", 32'(rsp_size), 32'(e.size));
                check("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    task automatic wait_ready();
        int g;
        g = 0;
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!req_ready) check("req_ready_wait", 32'(req_ready), 32'd1);
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] wdata);
        wait_ready();
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_size  = size;
        req_wdata = wdata;
        mem_ack   = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_size  = 2'($urandom_range(0, 3));
        req_wdata = $urandom;
    endtask

    // One access; delay = cycles mem_ack is withheld, delay >= T means never acked.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic [31:0] wdata, input logic [31:0] rd, input int delay);
        int          sh;
        logic        bad;
        logic        tout;
        logic [3:0]  be_e;
        logic [31:0] wd_e;
        logic [31:0] rd_e;
        int          lat_e;
        int          lat;
        int          last_req;
        rsp_t        e;

        sh   = int'(addr[1:0]);
        bad  = (size == 2'd3) || (size == 2'd1 && (sh % 2) != 0) || (size == 2'd2 && sh != 0);
        tout = !bad && delay >= T;
        case (size)
            2'd0:    be_e = 4'(1 << sh);
            2'd1:    be_e = 4'(3 << sh);
            default: be_e = 4'hf;
        endcase
        if (size == 2'd0)      wd_e = 32'(wdata[7:0]) * 32'h0101_0101;
        else if (size == 2'd1) wd_e = 32'(wdata[15:0]) * 32'h0001_0001;
        else                   wd_e = wdata;
        rd_e    = (!we && !bad && !tout) ? (rd >> (8 * sh)) : 32'h0;
        e.rdata = rd_e;
        e.size  = size;
        e.err   = bad || tout;
        exp_q.push_back(e);
        lat_e    = bad ? 1 : (tout ? T + 1 : delay + 2);
        last_req = tout ? T : delay + 1;

        issue(we, addr, size, wdata);
        lat = 0;
        for (int c = 1; c <= T + 3 && lat == 0; c++) begin
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (bad) check("mem_req_err_path", 32'(mem_req), 32'd0);
            if (rsp_valid) begin
                lat = c;
                if (!bad) check("mem_req_drop", 32'(mem_req), 32'd0);
                mem_ack = 1'($urandom_range(0, 1));
            end else if (!bad && c <= last_req) begin
                check("mem_req", 32'(mem_req), 32'd1);
                check("mem_addr", mem_addr, {addr[31:2], 2'b00});
                check("mem_be", 32'(mem_be), 32'(be_e));
                check("mem_we", 32'(mem_we), 32'(we));
                if (we) check("mem_wdata", mem_wdata, wd_e);
                if (!tout && c == delay + 1) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd;
                end
            end
        end
        check("latency", 32'(lat), 32'(lat_e));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_be"}, 32'(mem_be), 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, "_rsp_size"}, 32'(rsp_size), 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  s;

        rst_n     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_size  = 2'b00;
        req_wdata = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        #2 rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        txn(1'b0, 32'h0000_0100, 2'd2, 32'h0, 32'hDEAD_BEEF, 0);
        txn(1'b0, 32'h0000_0103, 2'd0, 32'h0, 32'h88AA_BBCC, 0);
        txn(1'b1, 32'h0000_0102, 2'd1, 32'h0000_1234, 32'h5555_5555, 0);
        txn(1'b0, 32'h0000_0101, 2'd1, 32'h0, 32'h1111_1111, 0);
        txn(1'b0, 32'h0000_0100, 2'd3, 32'h0, 32'h2222_2222, 0);
        txn(1'b0, 32'h0000_0104, 2'd2, 32'h0, 32'h3333_3333, T);
        txn(1'b0, 32'h0000_0106, 2'd1, 32'h0, 32'hCAFE_F00D, T - 1);

        // Reset in the middle of an access that has waited three cycles.
        issue(1'b0, 32'h0000_0200, 2'd2, 32'h0);
        repeat (3) begin
            @(negedge clk);
            mem_ack = 1'b0;
            check("pre_reset_mem_req", 32'(mem_req), 32'd1);
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) begin
            @(negedge clk);
            check("reset_no_rsp", 32'(rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        txn(1'b0, 32'h0000_0202, 2'd1, 32'h0, 32'hABCD_1234, 1);

        for (int i = 0; i < 250; i++) begin
            a = $urandom;
            s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                if (s == 2'd1) a[0] = 1'b0;
                if (s == 2'd2) a[1:0] = 2'b00;
            end
            txn(1'($urandom_range(0, 1)), a, s, $urandom, $urandom, $urandom_range(0, T + 1));
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
